// File: rtl/mem_rr_arbiter3.sv
// Three-port memory bus arbiter (0=instr, 1=data, 2=DMA): round-robin with
// optional per-port bus lock, registered downstream cycle, and no-ack watchdog.
module mem_rr_arbiter3 #(
  parameter int unsigned NUM_PORTS = 3,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_PORTS*19-1:0] m_addr,
  input  logic [NUM_PORTS*16-1:0] m_data_out,
  output logic [NUM_PORTS*16-1:0] m_data_in,
  input  logic [NUM_PORTS-1:0]    m_access,
  input  logic [NUM_PORTS-1:0]    m_wr_en,
  input  logic [NUM_PORTS*2-1:0]  m_bytesel,
  input  logic [NUM_PORTS-1:0]    m_lock,
  output logic [NUM_PORTS-1:0]    m_ack,
  output logic [NUM_PORTS-1:0]    m_err,
  output logic [18:0]             q_m_addr,
  output logic [15:0]             q_m_data_out,
  input  logic [15:0]             q_m_data_in,
  output logic                    q_m_access,
  input  logic                    q_m_ack,
  output logic                    q_m_wr_en,
  output logic [1:0]              q_m_bytesel,
  output logic                    q_b,
  output logic [1:0]              grant_id
);

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 2;
  localparam int unsigned PW = 2;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [PW-1:0]           rr_ptr, rr_nxt;
  logic [PW-1:0]           grant_nxt;
  logic                    locked, locked_nxt;
  logic [CNT_W-1:0]        wdog, wdog_nxt;
  logic [AW-1:0]           addr_nxt;
  logic [DW-1:0]           dout_nxt;
  logic                    access_nxt;
  logic                    wr_nxt;
  logic [BW-1:0]           bs_nxt;
  logic [NUM_PORTS*DW-1:0] din_nxt;
  logic [NUM_PORTS-1:0]    ack_nxt;
  logic [NUM_PORTS-1:0]    err_nxt;
  logic                    qb_nxt;

  logic                    arb_found;
  logic [PW-1:0]           arb_win;
  logic [PW-1:0]           cand;
  logic [AW-1:0]           sel_addr;
  logic [DW-1:0]           sel_dout;
  logic                    sel_wr;
  logic [BW-1:0]           sel_bs;
  logic                    resp_valid;
  logic [DW-1:0]           resp_data;

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
  endfunction

  // Winner: a locked owner that is still requesting, else first requester from rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_win   = rr_ptr;
    cand      = rr_ptr;
    if (locked && m_access[grant_id]) begin
      arb_found = 1'b1;
      arb_win   = grant_id;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (!arb_found && m_access[cand]) begin
          arb_found = 1'b1;
          arb_win   = cand;
        end
        cand = next_port(cand);
      end
    end
  end

  // Request fields of the winning port
  always_comb begin
    sel_addr = '0;
    sel_dout = '0;
    sel_wr   = 1'b0;
    sel_bs   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (arb_win == PW'(i)) begin
        sel_addr = m_addr[i*AW +: AW];
        sel_dout = m_data_out[i*DW +: DW];
        sel_wr   = m_wr_en[i];
        sel_bs   = m_bytesel[i*BW +: BW];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt  = state;
    rr_nxt     = rr_ptr;
    grant_nxt  = grant_id;
    locked_nxt = locked;
    wdog_nxt   = wdog;
    addr_nxt   = q_m_addr;
    dout_nxt   = q_m_data_out;
    access_nxt = q_m_access;
    wr_nxt     = q_m_wr_en;
    bs_nxt     = q_m_bytesel;
    din_nxt    = m_data_in;
    ack_nxt    = '0;
    err_nxt    = '0;
    qb_nxt     = 1'b0;
    resp_valid = 1'b0;
    resp_data  = '0;

    case (state)
      S_IDLE: begin
        if (locked && !m_access[grant_id]) begin
          locked_nxt = 1'b0;
        end
        if (arb_found) begin
          grant_nxt  = arb_win;
          addr_nxt   = sel_addr;
          dout_nxt   = sel_dout;
          wr_nxt     = sel_wr;
          bs_nxt     = sel_bs;
          access_nxt = 1'b1;
          wdog_nxt   = '0;
          state_nxt  = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        // A real ack on the watchdog's last cycle takes priority over the abort
        if (q_m_ack || (wdog == WDOG_LAST)) begin
          resp_valid        = 1'b1;
          resp_data         = q_m_ack ? q_m_data_in : '1;
          ack_nxt[grant_id] = 1'b1;
          err_nxt[grant_id] = !q_m_ack;
          access_nxt        = 1'b0;
          rr_nxt            = next_port(grant_id);
          locked_nxt        = q_m_ack && m_lock[grant_id];
          state_nxt         = S_RELEASE;
        end else begin
          wdog_nxt = wdog + CNT_W'(1);
        end
      end

      S_RELEASE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (resp_valid && (grant_id == PW'(i))) begin
        din_nxt[i*DW +: DW] = resp_data;
      end
    end

    qb_nxt = (state_nxt != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      locked       <= 1'b0;
      wdog         <= '0;
      q_m_addr     <= '0;
      q_m_data_out <= '0;
      q_m_access   <= 1'b0;
      q_m_wr_en    <= 1'b0;
      q_m_bytesel  <= '0;
      m_data_in    <= '0;
      m_ack        <= '0;
      m_err        <= '0;
      q_b          <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_nxt;
      grant_id     <= grant_nxt;
      locked       <= locked_nxt;
      wdog         <= wdog_nxt;
      q_m_addr     <= addr_nxt;
      q_m_data_out <= dout_nxt;
      q_m_access   <= access_nxt;
      q_m_wr_en    <= wr_nxt;
      q_m_bytesel  <= bs_nxt;
      m_data_in    <= din_nxt;
      m_ack        <= ack_nxt;
      m_err        <= err_nxt;
      q_b          <= qb_nxt;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter3.sv
// Scoreboard bench for mem_rr_arbiter3: transaction-level reference model
// predicts grants and acks; a negedge monitor compares DUT against them.
module tb_mem_rr_arbiter3;

  localparam int unsigned TB_TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic [56:0] m_addr;
  logic [47:0] m_data_out;
  logic [47:0] m_data_in;
  logic [2:0]  m_access;
  logic [2:0]  m_wr_en;
  logic [5:0]  m_bytesel;
  logic [2:0]  m_lock;
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [18:0] q_m_addr;
  logic [15:0] q_m_data_out;
  logic [15:0] q_m_data_in;
  logic        q_m_access;
  logic        q_m_ack;
  logic        q_m_wr_en;
  logic [1:0]  q_m_bytesel;
  logic        q_b;
  logic [1:0]  grant_id;

  mem_rr_arbiter3 #(.NUM_PORTS(3), .TIMEOUT(TB_TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .m_addr(m_addr), .m_data_out(m_data_out), .m_data_in(m_data_in),
    .m_access(m_access), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
    .m_lock(m_lock), .m_ack(m_ack), .m_err(m_err),
    .q_m_addr(q_m_addr), .q_m_data_out(q_m_data_out), .q_m_data_in(q_m_data_in),
    .q_m_access(q_m_access), .q_m_ack(q_m_ack), .q_m_wr_en(q_m_wr_en),
    .q_m_bytesel(q_m_bytesel), .q_b(q_b), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          edge_no;
    logic [1:0]  port;
    logic [18:0] addr;
    logic [15:0] data;
    logic        wr;
    logic [1:0]  bs;
  } grant_t;

  typedef struct {
    int          edge_no;
    logic [1:0]  port;
    logic        err;
    logic [47:0] din;
  } ack_t;

  grant_t gq[$];
  ack_t   aq[$];
  int     gnt_log[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state (transaction level)
  int          edge_cnt = 0;
  bit          rst_seen = 1'b0;
  bit          exp_qb = 1'b0;
  logic [1:0]  exp_gid = 2'd0;
  bit          mdl_busy = 1'b0;
  bit          mdl_lock = 1'b0;
  int          mdl_rr = 0;
  int          mdl_last = 0;
  int          mdl_start = 0;
  int          mdl_free = 0;
  logic [15:0] mdl_data [3];

  // Stimulus controls
  int          ack_mode;
  bit          rand_mode;
  logic [2:0]  keep;
  logic [15:0] fixed_data;

  // Reference model: evaluates each edge from the sampled bench inputs
  always @(posedge clk) begin
    bit     done;
    int     w;
    grant_t g;
    ack_t   a;
    edge_cnt++;
    rst_seen = reset;
    done = 1'b0;
    if (reset) begin
      mdl_busy = 1'b0;
      mdl_lock = 1'b0;
      mdl_rr   = 0;
      mdl_last = 0;
      mdl_free = 0;
      for (int i = 0; i < 3; i++) mdl_data[i] = 16'h0000;
      gq.delete();
      aq.delete();
    end else if (mdl_busy) begin
      if (q_m_ack || ((edge_cnt - mdl_start) == int'(TB_TIMEOUT))) begin
        mdl_data[mdl_last] = q_m_ack ? q_m_data_in : 16'hFFFF;
        a.edge_no = edge_cnt;
        a.port    = 2'(mdl_last);
        a.err     = !q_m_ack;
        a.din     = {mdl_data[2], mdl_data[1], mdl_data[0]};
        aq.push_back(a);
        mdl_lock = q_m_ack ? m_lock[mdl_last] : 1'b0;
        mdl_rr   = (mdl_last + 1) % 3;
        mdl_busy = 1'b0;
        mdl_free = edge_cnt + 2;
        done     = 1'b1;
      end
    end else if (edge_cnt >= mdl_free) begin
      if (mdl_lock && !m_access[mdl_last]) mdl_lock = 1'b0;
      w = -1;
      if (mdl_lock) w = mdl_last;
      else begin
        for (int k = 0; k < 3; k++)
          if (w < 0 && m_access[(mdl_rr + k) % 3]) w = (mdl_rr + k) % 3;
      end
      if (w >= 0) begin
        g.edge_no = edge_cnt;
        g.port    = 2'(w);
        g.addr    = m_addr[w*19 +: 19];
        g.data    = m_data_out[w*16 +: 16];
        g.wr      = m_wr_en[w];
        g.bs      = m_bytesel[w*2 +: 2];
        gq.push_back(g);
        mdl_last  = w;
        mdl_busy  = 1'b1;
        mdl_start = edge_cnt;
      end
    end
    exp_qb  = mdl_busy || done;
    exp_gid = 2'(mdl_last);
  end

  // Monitor: compares DUT outputs against queued expectations
  grant_t mon_g;
  grant_t cur_g;
  ack_t   mon_a;
  bit     prev_acc = 1'b0;
  bit     unexp_g;
  bit     unexp_a;
  bit     hold_bad;

  always @(negedge clk) begin
    if (rst_seen) begin
      n_cmp++;
      if ({q_m_addr, q_m_data_out, q_m_access, q_m_wr_en, q_m_bytesel,
           m_ack, m_err, m_data_in, q_b, grant_id} != '0) begin
        n_fail++;
        $display("FAIL reset_zero @%0d: got acc=%b ack=%b err=%b din=%h qb=%b gid=%0d addr=%h, want all zero",
                 edge_cnt, q_m_access, m_ack, m_err, m_data_in, q_b, grant_id, q_m_addr);
      end
    end else begin
      unexp_g = 1'b0;
      unexp_a = 1'b0;
      if (gq.size() > 0 && gq[0].edge_no == edge_cnt) begin
        mon_g = gq.pop_front();
        cur_g = mon_g;
        n_cmp++;
        if (!(q_m_access && !prev_acc) || grant_id != mon_g.port || q_m_addr != mon_g.addr ||
            q_m_data_out != mon_g.data || q_m_wr_en != mon_g.wr || q_m_bytesel != mon_g.bs) begin
          n_fail++;
          $display("FAIL grant @%0d: got acc=%b id=%0d addr=%h dout=%h wr=%b bs=%b, want acc-rise id=%0d addr=%h dout=%h wr=%b bs=%b",
                   edge_cnt, q_m_access, grant_id, q_m_addr, q_m_data_out, q_m_wr_en, q_m_bytesel,
                   mon_g.port, mon_g.addr, mon_g.data, mon_g.wr, mon_g.bs);
        end
      end else if (q_m_access && !prev_acc) begin
        unexp_g = 1'b1;
      end
      if (aq.size() > 0 && aq[0].edge_no == edge_cnt) begin
        mon_a = aq.pop_front();
        n_cmp++;
        if (m_ack != (3'd1 << mon_a.port) || m_err != (mon_a.err ? (3'd1 << mon_a.port) : 3'd0) ||
            m_data_in != mon_a.din || q_m_access) begin
          n_fail++;
          $display("FAIL ack @%0d: got ack=%b err=%b din=%h acc=%b, want port=%0d err=%b din=%h acc=0",
                   edge_cnt, m_ack, m_err, m_data_in, q_m_access, mon_a.port, mon_a.err, mon_a.din);
        end
      end else if (m_ack != 3'd0 || m_err != 3'd0) begin
        unexp_a = 1'b1;
      end
      hold_bad = q_m_access && (q_m_addr != cur_g.addr || q_m_data_out != cur_g.data ||
                                q_m_wr_en != cur_g.wr || q_m_bytesel != cur_g.bs);
      n_cmp++;
      if (unexp_g || unexp_a || hold_bad || q_b !== exp_qb || grant_id !== exp_gid) begin
        n_fail++;
        $display("FAIL cycle @%0d: got qb=%b gid=%0d ack=%b err=%b unexp_grant=%b hold_bad=%b, want qb=%b gid=%0d no stray ack/grant",
                 edge_cnt, q_b, grant_id, m_ack, m_err, unexp_g, hold_bad, exp_qb, exp_gid);
      end
    end
    if (q_m_access && !prev_acc) gnt_log.push_back(int'(grant_id));
    prev_acc = q_m_access;
  end

  task automatic check_v(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  function automatic int log_at(input int k);
    return (k < gnt_log.size()) ? gnt_log[k] : -1;
  endfunction

  task automatic set_req(input int i, input logic [18:0] a, input logic [15:0] d,
                         input logic wr, input logic [1:0] bs, input logic lk);
    m_access[i]          = 1'b1;
    m_addr[i*19 +: 19]   = a;
    m_data_out[i*16 +: 16] = d;
    m_wr_en[i]           = wr;
    m_bytesel[i*2 +: 2]  = bs;
    m_lock[i]            = lk;
  endtask

  task automatic new_req(input int i);
    set_req(i, 19'($urandom), 16'($urandom), 1'($urandom), 2'($urandom), ($urandom % 100) < 30);
  endtask

  // One clock: drive responder and requester behaviour after the edge
  task automatic step();
    @(posedge clk);
    #1;
    case (ack_mode)
      0: begin
        q_m_ack     = q_m_access ? (($urandom % 100) < 35) : (($urandom % 100) < 10);
        q_m_data_in = 16'($urandom);
      end
      1: begin
        q_m_ack     = q_m_access;
        q_m_data_in = fixed_data;
      end
      default: begin
        q_m_ack     = 1'b0;
        q_m_data_in = 16'($urandom);
      end
    endcase
    for (int i = 0; i < 3; i++) begin
      if (m_ack[i]) begin
        if (rand_mode) begin
          if ($urandom % 2) new_req(i);
          else m_access[i] = 1'b0;
        end else if (!keep[i]) begin
          m_access[i] = 1'b0;
        end
      end else if (rand_mode) begin
        if (!m_access[i] && ($urandom % 100) < 30) new_req(i);
        else if (m_access[i] && ($urandom % 100) < 2) m_access[i] = 1'b0;
      end
    end
    if (rand_mode) reset = (($urandom % 400) == 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int j;
    reset = 1'b1;
    m_addr = '0; m_data_out = '0; m_access = '0; m_wr_en = '0; m_bytesel = '0; m_lock = '0;
    q_m_ack = 1'b0; q_m_data_in = '0;
    ack_mode = 1; rand_mode = 1'b0; keep = 3'b000; fixed_data = 16'hBEEF;
    repeat (3) step();
    reset = 1'b0;

    // Single port-0 transfer with immediate downstream ack
    set_req(0, 19'h12345, 16'h1234, 1'b1, 2'b11, 1'b0);
    repeat (8) step();
    check_v("t1_q_m_addr", q_m_addr, 19'h12345);
    check_v("t1_din0", m_data_in[15:0], 16'hBEEF);

    // Fairness with all three requesting continuously
    pulse_reset();
    gnt_log.delete();
    keep = 3'b111;
    for (int i = 0; i < 3; i++) new_req(i);
    m_lock = 3'b000;
    repeat (20) step();
    for (int k = 0; k < 6; k++) check_v($sformatf("t2_seq%0d", k), log_at(k), k % 3);
    keep = 3'b000;
    repeat (15) step();

    // Round-robin pointer at 1 with ports 0 and 2 requesting
    pulse_reset();
    set_req(0, 19'h00001, 16'h0001, 1'b0, 2'b01, 1'b0);
    repeat (6) step();
    gnt_log.delete();
    set_req(0, 19'h00010, 16'h0010, 1'b0, 2'b10, 1'b0);
    set_req(2, 19'h00020, 16'h0020, 1'b1, 2'b11, 1'b0);
    repeat (10) step();
    check_v("t3_first", log_at(0), 2);
    check_v("t3_second", log_at(1), 0);

    // Bus lock held by port 1, then released
    pulse_reset();
    gnt_log.delete();
    keep = 3'b111;
    set_req(0, 19'h00100, 16'h0100, 1'b0, 2'b11, 1'b0);
    set_req(1, 19'h00200, 16'h0200, 1'b1, 2'b11, 1'b1);
    set_req(2, 19'h00300, 16'h0300, 1'b0, 2'b11, 1'b0);
    repeat (12) step();
    m_lock[1] = 1'b0;
    repeat (12) step();
    check_v("t4_g0", log_at(0), 0);
    check_v("t4_g1", log_at(1), 1);
    check_v("t4_g2", log_at(2), 1);
    j = 1;
    while (j < gnt_log.size() && gnt_log[j] == 1) j++;
    check_v("t4_after_lock", log_at(j), 2);
    keep = 3'b000;
    repeat (12) step();

    // Watchdog timeout with downstream never acking
    ack_mode = 2;
    set_req(1, 19'h0ABCD, 16'h5555, 1'b0, 2'b11, 1'b0);
    repeat (10) step();
    check_v("t5_din1", m_data_in[31:16], 16'hFFFF);
    check_v("t5_idle", q_b, 0);
    ack_mode = 1;
    repeat (2) step();

    // Reset during ACTIVE with a late ack right after
    ack_mode = 2;
    set_req(1, 19'h01111, 16'h1111, 1'b0, 2'b11, 1'b0);
    j = 0;
    while (j < 10 && !q_m_access) begin
      step();
      j++;
    end
    check_v("t6_reached_active", q_m_access, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    gnt_log.delete();
    q_m_ack = 1'b1;
    ack_mode = 1;
    set_req(2, 19'h02222, 16'h2222, 1'b1, 2'b11, 1'b0);
    repeat (10) step();
    check_v("t6_first_after_reset", log_at(0), 1);
    check_v("t6_second_after_reset", log_at(1), 2);

    // Randomized traffic with random acks, spurious acks, locks, drops and resets
    ack_mode = 0;
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    reset = 1'b0;
    keep = 3'b000;
    ack_mode = 1;
    repeat (30) step();
    m_access = 3'b000;
    repeat (6) step();
    check_v("drain_grants", gq.size(), 0);
    check_v("drain_acks", aq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rr_arbiter3.md
Name: mem_rr_arbiter3

Overview:
- Three-requester memory bus arbiter: instruction fetch, data, DMA. Sits between CPU/DMA masters and the single SDRAM/cache port.
- Round-robin fairness, optional bus lock per requester, registered request latching, and a no-ack watchdog that terminates hung cycles.
- Replaces fixed two-way instruction/data sharing when DMA becomes a third master.

Parameters:
- NUM_PORTS, 3, number of requesters. Fixed at 3 for this revision. Index 0=instr, 1=data, 2=DMA.
- TIMEOUT, 255, cycles in ACTIVE without q_m_ack before abort. Range 1..65535.
- CNT_W, 16, width of the watchdog counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_addr  in  3*19  per-port word address [19:1]; port i at bits [19*i+18:19*i]
- m_data_out  in  3*16  per-port write data
- m_data_in  out  3*16  per-port read data, registered
- m_access  in  3  per-port request, held until that port's ack
- m_wr_en  in  3  per-port write enable
- m_bytesel  in  3*2  per-port byte selects
- m_lock  in  3  per-port lock: keep grant for the next request
- m_ack  out  3  per-port one-cycle ack, registered
- m_err  out  3  per-port one-cycle error, coincident with m_ack on timeout
- q_m_addr  out  19  downstream address, registered
- q_m_data_out  out  16  downstream write data, registered
- q_m_data_in  in  16  downstream read data
- q_m_access  out  1  downstream request, registered
- q_m_ack  in  1  downstream completion
- q_m_wr_en  out  1  downstream write enable, registered
- q_m_bytesel  out  2  downstream byte selects, registered
- q_b  out  1  bus busy: high in ACTIVE and RELEASE
- grant_id  out  2  index of current/last winner

Behaviour:
- Reset (sync): state=IDLE; rr_ptr=0; grant_id=0; locked=0; watchdog=0. All outputs are 0: q_m_*, m_ack, m_err, m_data_in, q_b.
- FSM states: IDLE, ACTIVE, RELEASE.
- IDLE:
  - If locked=1 and m_access[grant_id]=1, grant_id wins regardless of rr_ptr.
  - Else the winner is the first requester with m_access=1, scanning from rr_ptr upward mod 3.
  - On a winner: latch its addr/data_out/wr_en/bytesel into q_m_*; set q_m_access=1; grant_id=winner; watchdog=0; go to ACTIVE.
  - Latency: a request sampled at edge N drives q_m_access=1 after edge N.
  - With no request, stay in IDLE. If locked=1 and the locked port has no request, clear locked and arbitrate normally the same cycle.
- ACTIVE:
  - q_m_* are held stable, and requester inputs are ignored.
  - On q_m_ack=1:
    - m_ack[grant_id]=1 for one cycle.
    - m_data_in[grant_id] = q_m_data_in. Other ports' m_data_in keep their previous values.
    - q_m_access=0.
    - rr_ptr = (grant_id+1) mod 3.
    - locked = m_lock[grant_id].
    - Go to RELEASE.
  - Without q_m_ack, watchdog increments each cycle. When watchdog == TIMEOUT-1 and still no ack:
    - m_ack[grant_id]=1 and m_err[grant_id]=1.
    - m_data_in[grant_id]=16'hFFFF.
    - q_m_access=0.
    - rr_ptr advances.
    - locked=0.
    - Go to RELEASE.
  - If q_m_ack arrives on the timeout cycle, ack wins and no error is raised.
- RELEASE: one cycle, with q_m_access=0 and no arbitration, so the requester can drop m_access. Then go to IDLE.
- Throughput: minimum 3 cycles per transfer (IDLE, ACTIVE with 1-cycle ack, RELEASE).
- q_m_ack outside ACTIVE is ignored, so no ack is routed to any port.
- Only grant_id ever gets m_ack/m_err. At most one bit of m_ack is high at any time.
- Requester dropping m_access mid-ACTIVE: the downstream cycle still completes and the ack is still pulsed.
- Reset asserted in any state aborts immediately to IDLE, with no ack issued.
- Fairness: with all three continuously requesting and no lock, grants go 0,1,2,0,...

Test Plan:
- Reset, then m_access=3'b001 with addr=19'h12345 and q_m_ack one cycle after q_m_access → q_m_addr=19'h12345, m_ack=3'b001 for exactly 1 cycle, m_data_in[0]=q_m_data_in (16'hBEEF), q_b high for 2 cycles.
- All three requesting continuously, ack 1 cycle after each access → grant_id sequence 0,1,2,0,1,2; each port gets one ack per 9 cycles.
- rr_ptr=1, simultaneous m_access=3'b101 → port 2 wins first, then port 0.
- Port 1 with m_lock=1 and all ports requesting → port 1 granted twice in a row. Drop lock → next grant goes to port 2.
- TIMEOUT=4 and q_m_ack held 0 → after 4 ACTIVE cycles, m_ack[grant]=1, m_err[grant]=1, m_data_in=16'hFFFF, then IDLE.
- Reset pulsed during ACTIVE with q_m_ack arriving the next cycle → all outputs 0, no m_ack pulse, next request arbitrated from rr_ptr=0.
